instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_instr_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a small FIFO of machine words.
// Each accepted mnemonic plus its operands is turned into a 32-bit word in the
// same cycle and queued. The consumer drains the queue through a valid/ready
// handshake.

package common_def;
  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    NOP, ECALL, INVALID
  } instruction_type;
endpackage

module instr_encoder
  import common_def::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  instruction_type         in_type,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [31:0]             in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_instr,
  input  logic                    flush,
  output logic                    err,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [31:0]   NOP_WORD   = 32'h00000013;
  localparam logic [31:0]   ECALL_WORD = 32'h00000073;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Field layout selector; FMT_SH is the I-type variant carrying funct7 + shamt.
  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIX
  } fmt_t;

  fmt_t        w_fmt;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_fix;
  logic [31:0] w_enc;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic          r_started;

  logic w_full;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // Pick field layout and major opcode for the presented mnemonic.
  always_comb begin
    w_fmt = FMT_FIX;
    w_op  = OPC_OPIMM;
    w_fix = NOP_WORD;
    case (in_type)
      LUI:   begin w_fmt = FMT_U; w_op = OPC_LUI;   end
      AUIPC: begin w_fmt = FMT_U; w_op = OPC_AUIPC; end
      JAL:   begin w_fmt = FMT_J; w_op = OPC_JAL;   end
      JALR:  begin w_fmt = FMT_I; w_op = OPC_JALR;  end
      BEQ, BNE, BLT, BGE, BLTU, BGEU:
             begin w_fmt = FMT_B; w_op = OPC_BRANCH; end
      LB, LH, LW, LBU, LHU:
             begin w_fmt = FMT_I; w_op = OPC_LOAD;   end
      SB, SH, SW:
             begin w_fmt = FMT_S; w_op = OPC_STORE;  end
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI:
             begin w_fmt = FMT_I; w_op = OPC_OPIMM;  end
      SLLI, SRLI, SRAI:
             begin w_fmt = FMT_SH; w_op = OPC_OPIMM; end
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
             begin w_fmt = FMT_R; w_op = OPC_OP;     end
      ECALL: w_fix = ECALL_WORD;
      default: w_fix = NOP_WORD;
    endcase
  end

  // funct3 / funct7 for the mnemonic; only SUB, SRA and SRAI carry a nonzero funct7.
  always_comb begin
    w_f3 = 3'd0;
    w_f7 = 7'b0000000;
    case (in_type)
      BNE, LH, SH, SLLI, SLL:             w_f3 = 3'd1;
      LW, SW, SLTI, SLT:                  w_f3 = 3'd2;
      SLTIU, SLTU:                        w_f3 = 3'd3;
      BLT, LBU, XORI, XOR:                w_f3 = 3'd4;
      BGE, LHU, SRLI, SRAI, SRL, SRA:     w_f3 = 3'd5;
      BLTU, ORI, OR:                      w_f3 = 3'd6;
      BGEU, ANDI, AND:                    w_f3 = 3'd7;
      default:                            w_f3 = 3'd0;
    endcase
    if (in_type == SUB || in_type == SRA || in_type == SRAI) w_f7 = 7'b0100000;
  end

  // Assemble the machine word; immediate bits outside each field are simply dropped.
  always_comb begin
    w_enc = w_fix;
    case (w_fmt)
      FMT_R:  w_enc = {w_f7, in_rs2, in_rs1, w_f3, in_rd, w_op};
      FMT_I:  w_enc = {in_imm[11:0], in_rs1, w_f3, in_rd, w_op};
      FMT_SH: w_enc = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, w_op};
      FMT_S:  w_enc = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], w_op};
      FMT_B:  w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, w_f3,
                       in_imm[4:1], in_imm[11], w_op};
      FMT_U:  w_enc = {in_imm[31:12], in_rd, w_op};
      FMT_J:  w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_op};
      default: w_enc = w_fix;
    endcase
  end

  assign w_full    = (r_count == FULL_CNT);
  assign in_ready  = r_started && !w_full && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && (in_type != INVALID);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready && !flush;
  assign out_instr = out_valid ? r_mem[r_rptr] : NOP_WORD;
  assign err       = r_err;
  assign count     = r_count;

  // Queue bookkeeping: pointers, occupancy, error pulse and post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_err     <= w_accept && (in_type == INVALID);
      if (flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  // Word storage; contents are never reset, occupancy alone marks what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, fill/drain,
// INVALID handling, flush, asynchronous reset and a randomized scoreboard run.
module tb_instr_encoder;
  import common_def::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOPW = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  instruction_type in_type;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [31:0]     in_imm;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            flush;
  logic            err;
  logic [2:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .flush(flush), .err(err), .count(count)
  );

  // Reference encoder built directly from the RV32I field layouts.
  function automatic logic [31:0] ref_enc(input instruction_type t, input logic [31:0] rd,
                                          input logic [31:0] rs1, input logic [31:0] rs2,
                                          input logic [31:0] imm);
    logic [31:0] ip, sp, bp, up, jp, d, s1, s2, sh;
    ip = (imm & 32'hfff) << 20;
    sp = (((imm >> 5) & 32'h7f) << 25) | ((imm & 32'h1f) << 7);
    bp = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3f) << 25)
       | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'd1) << 7);
    up = imm & 32'hfffff000;
    jp = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
       | (((imm >> 11) & 32'd1) << 20) | (imm & 32'h000ff000);
    sh = (imm & 32'h1f) << 20;
    d  = rd << 7;
    s1 = rs1 << 15;
    s2 = rs2 << 20;
    case (t)
      LUI:   return up | d | 32'h37;
      AUIPC: return up | d | 32'h17;
      JAL:   return jp | d | 32'h6f;
      JALR:  return ip | s1 | d | 32'h67;
      BEQ:   return bp | s2 | s1 | (32'd0 << 12) | 32'h63;
      BNE:   return bp | s2 | s1 | (32'd1 << 12) | 32'h63;
      BLT:   return bp | s2 | s1 | (32'd4 << 12) | 32'h63;
      BGE:   return bp | s2 | s1 | (32'd5 << 12) | 32'h63;
      BLTU:  return bp | s2 | s1 | (32'd6 << 12) | 32'h63;
      BGEU:  return bp | s2 | s1 | (32'd7 << 12) | 32'h63;
      LB:    return ip | s1 | (32'd0 << 12) | d | 32'h03;
      LH:    return ip | s1 | (32'd1 << 12) | d | 32'h03;
      LW:    return ip | s1 | (32'd2 << 12) | d | 32'h03;
      LBU:   return ip | s1 | (32'd4 << 12) | d | 32'h03;
      LHU:   return ip | s1 | (32'd5 << 12) | d | 32'h03;
      SB:    return sp | s2 | s1 | (32'd0 << 12) | 32'h23;
      SH:    return sp | s2 | s1 | (32'd1 << 12) | 32'h23;
      SW:    return sp | s2 | s1 | (32'd2 << 12) | 32'h23;
      ADDI:  return ip | s1 | (32'd0 << 12) | d | 32'h13;
      SLTI:  return ip | s1 | (32'd2 << 12) | d | 32'h13;
      SLTIU: return ip | s1 | (32'd3 << 12) | d | 32'h13;
      XORI:  return ip | s1 | (32'd4 << 12) | d | 32'h13;
      ORI:   return ip | s1 | (32'd6 << 12) | d | 32'h13;
      ANDI:  return ip | s1 | (32'd7 << 12) | d | 32'h13;
      SLLI:  return sh | s1 | (32'd1 << 12) | d | 32'h13;
      SRLI:  return sh | s1 | (32'd5 << 12) | d | 32'h13;
      SRAI:  return 32'h40000000 | sh | s1 | (32'd5 << 12) | d | 32'h13;
      ADD:   return s2 | s1 | (32'd0 << 12) | d | 32'h33;
      SUB:   return 32'h40000000 | s2 | s1 | (32'd0 << 12) | d | 32'h33;
      SLL:   return s2 | s1 | (32'd1 << 12) | d | 32'h33;
      SLT:   return s2 | s1 | (32'd2 << 12) | d | 32'h33;
      SLTU:  return s2 | s1 | (32'd3 << 12) | d | 32'h33;
      XOR:   return s2 | s1 | (32'd4 << 12) | d | 32'h33;
      SRL:   return s2 | s1 | (32'd5 << 12) | d | 32'h33;
      SRA:   return 32'h40000000 | s2 | s1 | (32'd5 << 12) | d | 32'h33;
      OR:    return s2 | s1 | (32'd6 << 12) | d | 32'h33;
      AND:   return s2 | s1 | (32'd7 << 12) | d | 32'h33;
      ECALL: return 32'h00000073;
      default: return 32'h00000013;
    endcase
  endfunction

  task automatic put(input instruction_type t, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm);
    in_type = t;
    in_rd   = rd;
    in_rs1  = rs1;
    in_rs2  = rs2;
    in_imm  = imm;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    put(NOP, 5'd0, 5'd0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== NOPW) begin n_fail++; $display("FAIL reset_out_instr: got %h want %h", out_instr, NOPW); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", in_ready); end
    $display("test_reset done");
  endtask

  task automatic test_encodings();
    instruction_type vt [8] = '{ADDI, ADD, SUB, SRAI, LUI, BEQ, JAL, SW};
    logic [4:0]  vrd  [8] = '{5'd1, 5'd3, 5'd3, 5'd1, 5'd5, 5'd0, 5'd1, 5'd0};
    logic [4:0]  vrs1 [8] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1};
    logic [4:0]  vrs2 [8] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd2, 5'd0, 5'd2};
    logic [31:0] vimm [8] = '{32'd5, 32'd0, 32'd0, 32'd3, 32'h12345000, 32'd8, 32'd16, 32'd4};
    logic [31:0] vexp [8] = '{32'h00500093, 32'h002081B3, 32'h402081B3, 32'h4030D093,
                              32'h123452B7, 32'h00208463, 32'h010000EF, 32'h0020A223};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      put(vt[i], vrd[i], vrs1[i], vrs2[i], vimm[i]);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n_checks++;
      if (out_instr !== vexp[i]) begin
        n_fail++; $display("FAIL enc_%0d: got %h want %h", i, out_instr, vexp[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if (count !== 3'd0) begin n_fail++; $display("FAIL enc_pop_%0d: count %0d want 0", i, count); end
      $display("encode %s -> %h", vt[i].name(), vexp[i]);
    end
  endtask

  task automatic test_fill();
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = ref_enc(ADDI, k + 1, 0, 0, k + 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      put(ADDI, 5'(k + 1), 5'd0, 5'd0, 32'(k + 10));
      in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== (k < 4)) begin
        n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", k, in_ready, k < 4);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    repeat (3) begin
      n_checks++;
      if (out_instr !== w[0]) begin n_fail++; $display("FAIL fill_head_stable: got %h want %h", out_instr, w[0]); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (out_instr !== w[k]) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", k, out_instr, w[k]); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== NOPW) begin n_fail++; $display("FAIL drain_nop: got %h want %h", out_instr, NOPW); end
    out_ready = 1'b0;
    $display("test_fill done");
  endtask

  task automatic test_invalid();
    logic [31:0] a, b;
    a = ref_enc(ADDI, 7, 2, 0, 100);
    b = ref_enc(ADDI, 8, 3, 0, 200);
    @(negedge clk);
    put(ADDI, 5'd7, 5'd2, 5'd0, 32'd100); in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_pre: got %b want 0", err); end
    put(INVALID, 5'd9, 5'd9, 5'd9, 32'd9);
    @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err_pulse: got %b want 1", err); end
    put(ADDI, 5'd8, 5'd3, 5'd0, 32'd200);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL inv_err_end: got %b want 0", err); end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL inv_count: got %0d want 2", count); end
    n_checks++; if (out_instr !== a) begin n_fail++; $display("FAIL inv_first: got %h want %h", out_instr, a); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_instr !== b) begin n_fail++; $display("FAIL inv_second: got %h want %h", out_instr, b); end
    @(negedge clk);
    out_ready = 1'b0;
    $display("test_invalid done");
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      put(ORI, 5'(k), 5'd1, 5'd0, 32'(k)); in_valid = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    put(ADDI, 5'd1, 5'd1, 5'd0, 32'd1);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== NOPW) begin n_fail++; $display("FAIL flush_nop: got %h want %h", out_instr, NOPW); end
    @(negedge clk);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_no_accept: got %0d want 0", count); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      put(XORI, 5'(k + 4), 5'd2, 5'd0, 32'h55); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rmid_pre_count: got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== NOPW) begin n_fail++; $display("FAIL rmid_instr: got %h want %h", out_instr, NOPW); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready_back: got %b want 1", in_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count_after: got %0d want 0", count); end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic exp_err, exp_rdy, acc, pop;
    logic [31:0] w, exp_head;
    instruction_type t;
    exp_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      exp_head = (q.size() != 0) ? q[0] : NOPW;
      n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, count, q.size()); end
      n_checks++; if (out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b", c, out_valid); end
      n_checks++; if (out_instr !== exp_head) begin n_fail++; $display("FAIL rnd_instr c=%0d: got %h want %h", c, out_instr, exp_head); end
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err, exp_err); end
      t = instruction_type'($urandom_range(0, 39));
      put(t, 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = (q.size() < DEPTH) && !flush;
      n_checks++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready, exp_rdy); end
      acc = in_valid && exp_rdy;
      pop = (q.size() != 0) && out_ready && !flush;
      w = ref_enc(t, 32'(in_rd), 32'(in_rs1), 32'(in_rs2), in_imm);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc && t != INVALID) q.push_back(w);
      end
      exp_err = acc && (t == INVALID);
      if (acc) $display("rnd c=%0d accept %s word=%h", c, t.name(), w);
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_fill();
    test_invalid();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
